instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle sequencer for the 4-bit-opcode CPU datapath. It owns the PC and instruction register and fetches from instruction memory over a req/ack handshake. It presents the opcode to the combinational control unit, samples that unit's decoded outputs one cycle later, and turns them into a qualified one-cycle register-file write pulse and PC updates (sequential or branch). It sits between instruction memory, the control unit, the ALU zero flag and the register file.

## Interface
- PC_W, default 8: PC / instruction-memory address width.
- RET_W, default 16: retired-instruction counter width.

- CLK  in  1  sole clock, rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- RUN  in  1  level: 1 = execute, 0 = stop at the next instruction boundary.
- IMEM_REQ  out  1  fetch request, held until ack.
- IMEM_ADDR  out  PC_W  fetch address; equals PC.
- IMEM_ACK  in  1  fetch data valid this cycle.
- IMEM_DATA  in  32  fetched instruction.
- INSTRUCTION  out  32  instruction register (IR) to datapath.
- OPCODE  out  4  IR[27:24], to control unit.
- CU_WRITEENABLE, CU_BRAZ, CU_BRANZ, CU_BRAUNCOND  in  1 each  control-unit outputs.
- ZERO  in  1  ALU zero flag.
- REG_WE  out  1  qualified register-file write strobe.
- PC  out  PC_W  program counter.
- BUSY  out  1  1 in any state except IDLE and HALT.
- HALTED  out  1  1 in HALT.
- ILLEGAL  out  1  sticky; set on opcode 4'b1100–4'b1111.
- RETIRED  out  RET_W  count of completed instructions, saturating.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Reset (RESET_N=0 at an edge, any state): go to IDLE. PC, IR, IMEM_REQ, REG_WE, BUSY, HALTED, ILLEGAL and RETIRED all become 0. OPCODE and IMEM_ADDR therefore read 0. An in-flight fetch is abandoned and an IMEM_ACK in the same cycle is ignored.
- IDLE: RUN=1 → FETCH.
- FETCH: IMEM_REQ=1 and IMEM_ADDR=PC, both held stable until IMEM_ACK=1. On ack: IR←IMEM_DATA, → DECODE, and IMEM_REQ=0 from the next cycle. IMEM_ACK in any other state is ignored.
- DECODE: one settle cycle for the control unit.
  - If OPCODE≥4'b1100: ILLEGAL←1, then behaviour per Configuration.
  - Otherwise → EXEC.
- EXEC: sample CU_* and ZERO. taken = CU_BRAUNCOND | (CU_BRAZ & ZERO) | (CU_BRANZ & ~ZERO).
  - Branch op (any CU_BR* = 1): PC←taken ? PC+1+sext(IR[7:0]) : PC+1. Retire. → FETCH if RUN, else IDLE.
  - Otherwise: capture CU_WRITEENABLE, → WB.
- WB: REG_WE = captured CU_WRITEENABLE (X is treated as 0) for exactly this cycle. PC←PC+1. Retire. → FETCH if RUN, else IDLE.
- HALT: terminal. HALTED=1, no fetches. Only reset exits.
- PC arithmetic is modulo 2^PC_W. The 8-bit offset is sign-extended to PC_W, or truncated when PC_W<8.
- RETIRED increments by 1 per retire and saturates at all-ones.
- Dropping RUN mid-instruction never aborts: the current instruction completes, then the sequencer enters IDLE with PC pointing at the next instruction. Raising RUN from IDLE resumes from that PC.

## Timing
- All outputs are registered, except that OPCODE and INSTRUCTION follow IR and IMEM_ADDR follows PC directly.
- With ack on the first FETCH cycle:
  - ALU/mov instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - Each cycle of ack delay adds one cycle.
- The control unit's internal #1 delay is absorbed by the DECODE cycle. CU_* inputs are sampled only in EXEC.
- Back-to-back under RUN=1: FETCH of the next instruction starts the cycle after WB or branch EXEC.
- REG_WE is never high outside WB and never high for more than one cycle per instruction.

## Configuration
- SEQ_HALT_ON_ILLEGAL_EN defined: an illegal opcode in DECODE → HALT. PC stays at the illegal instruction's address, the instruction is not retired, and REG_WE is not asserted.
- SEQ_HALT_ON_ILLEGAL_EN undefined: an illegal opcode executes as a NOP. DECODE → WB with the captured write enable forced to 0, then PC←PC+1 and the instruction is retired. ILLEGAL still sets and stays sticky.

## Test plan
- Reset then RUN=1, memory {0:add, 1:addi}, ack in 1 cycle → REG_WE pulses in cycles 4 and 8, PC=2, RETIRED=2.
- Braz at PC=5, IR[7:0]=8'hFD, ZERO=1 → PC=3 after EXEC and no REG_WE. Repeat with ZERO=0 → PC=6.
- Brauncond at PC=8'hFE, offset 8'h03 → PC wraps to 8'h02.
- Ack delayed 3 cycles → IMEM_REQ and IMEM_ADDR stay stable for 4 cycles. An ack in DECODE is ignored.
- Opcode 4'b1110 → ILLEGAL=1. With the macro: HALTED=1, PC unchanged. Without it: PC+1, RETIRED+1, no REG_WE.
- RESET_N=0 during WB, and separately RUN=0 during FETCH → reset: all outputs 0 the next cycle, no REG_WE. RUN drop: the instruction completes, then IDLE with BUSY=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/WB sequencer that owns the PC
// and instruction register. It fetches over a req/ack handshake, gives the
// combinational control unit one cycle to settle, and turns the decoded
// controls into a one-cycle register-file write strobe and PC updates.
// Optional build macro: SEQ_HALT_ON_ILLEGAL_EN. When it is defined, an illegal
// opcode (4'hC..4'hF) halts the sequencer. Otherwise the opcode runs as a NOP.
module instr_sequencer #(
    parameter int PC_W  = 8,
    parameter int RET_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             RUN,
    output logic             IMEM_REQ,
    output logic [PC_W-1:0]  IMEM_ADDR,
    input  logic             IMEM_ACK,
    input  logic [31:0]      IMEM_DATA,
    output logic [31:0]      INSTRUCTION,
    output logic [3:0]       OPCODE,
    input  logic             CU_WRITEENABLE,
    input  logic             CU_BRAZ,
    input  logic             CU_BRANZ,
    input  logic             CU_BRAUNCOND,
    input  logic             ZERO,
    output logic             REG_WE,
    output logic [PC_W-1:0]  PC,
    output logic             BUSY,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [RET_W-1:0] RETIRED
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic             we_cap_q, we_cap_d;
    logic             imem_req_q, imem_req_d;
    logic             reg_we_q, reg_we_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [RET_W-1:0] retired_q, retired_d;

    logic             is_illegal;
    logic             is_branch;
    logic             taken;
    logic             retire;
    logic [PC_W-1:0]  branch_off;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_target;

    // Decode helpers: sign-extended (or truncated) branch offset, candidate PCs, branch condition
    always_comb begin
        branch_off = PC_W'($signed(ir_q[7:0]));
        pc_inc     = pc_q + PC_W'(1);
        pc_target  = pc_inc + branch_off;
        is_illegal = (ir_q[27:24] >= 4'hC);
        is_branch  = CU_BRAZ | CU_BRANZ | CU_BRAUNCOND;
        taken      = CU_BRAUNCOND | (CU_BRAZ & ZERO) | (CU_BRANZ & ~ZERO);
    end

    // Next-state and next-output logic; outputs are derived from the state being entered
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        we_cap_d  = we_cap_q;
        illegal_d = illegal_q;
        retire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RUN) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (IMEM_ACK) begin
                    ir_d    = IMEM_DATA;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_illegal) begin
                    illegal_d = 1'b1;
`ifdef SEQ_HALT_ON_ILLEGAL_EN
                    state_d   = ST_HALT;
`else
                    we_cap_d  = 1'b0;
                    state_d   = ST_WB;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_branch) begin
                    pc_d    = taken ? pc_target : pc_inc;
                    retire  = 1'b1;
                    state_d = RUN ? ST_FETCH : ST_IDLE;
                end else begin
                    // An unknown write enable falls through to the else branch, i.e. no write
                    if (CU_WRITEENABLE == 1'b1) begin
                        we_cap_d = 1'b1;
                    end else begin
                        we_cap_d = 1'b0;
                    end
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_d    = pc_inc;
                retire  = 1'b1;
                state_d = RUN ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        retired_d  = (retire && (retired_q != '1)) ? retired_q + RET_W'(1) : retired_q;
        imem_req_d = (state_d == ST_FETCH);
        busy_d     = !((state_d == ST_IDLE) || (state_d == ST_HALT));
        halted_d   = (state_d == ST_HALT);
        reg_we_d   = (state_d == ST_WB) & we_cap_d;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            we_cap_q   <= 1'b0;
            imem_req_q <= 1'b0;
            reg_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            we_cap_q   <= we_cap_d;
            imem_req_q <= imem_req_d;
            reg_we_q   <= reg_we_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    assign IMEM_REQ    = imem_req_q;
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign INSTRUCTION = ir_q;
    assign OPCODE      = ir_q[27:24];
    assign REG_WE      = reg_we_q;
    assign BUSY        = busy_q;
    assign HALTED      = halted_q;
    assign ILLEGAL     = illegal_q;
    assign RETIRED     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed programs run against an instruction-level model
// that expands each instruction into its expected per-cycle outputs.
// The counter is narrowed to 4 bits so that saturation can be reached.
module tb_instr_sequencer;

    localparam int PC_W  = 8;
    localparam int RET_W = 4;
    localparam logic [RET_W-1:0] RET_MAX = '1;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             RUN = 1'b0;
    logic             IMEM_ACK = 1'b0;
    logic [31:0]      IMEM_DATA = 32'h0;
    logic             ZERO = 1'b0;
    logic             IMEM_REQ;
    logic [PC_W-1:0]  IMEM_ADDR;
    logic [31:0]      INSTRUCTION;
    logic [3:0]       OPCODE;
    logic             CU_WRITEENABLE;
    logic             CU_BRAZ;
    logic             CU_BRANZ;
    logic             CU_BRAUNCOND;
    logic             REG_WE;
    logic [PC_W-1:0]  PC;
    logic             BUSY;
    logic             HALTED;
    logic             ILLEGAL;
    logic [RET_W-1:0] RETIRED;

    typedef struct packed {
        logic        req;
        logic        busy;
        logic        halted;
        logic        reg_we;
        logic [7:0]  pc;
        logic [3:0]  ret;
        logic        ill;
        logic        ir_valid;
        logic [31:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          we_log[$];
    int          req_log[$];
    int          run_cycle = 0;
    int          vectors = 0;
    int          errors = 0;
    logic [31:0] mem [0:255];

    int          ack_delay = 0;
    logic        extra_ack = 1'b0;
    logic        ack_hold = 1'b0;
    int          wait_cnt = 0;

    logic [7:0]  m_pc = 8'h0;
    logic [3:0]  m_ret = 4'h0;
    logic        m_ill = 1'b0;
    logic        m_halt = 1'b0;

    instr_sequencer #(.PC_W(PC_W), .RET_W(RET_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .INSTRUCTION(INSTRUCTION), .OPCODE(OPCODE),
        .CU_WRITEENABLE(CU_WRITEENABLE), .CU_BRAZ(CU_BRAZ), .CU_BRANZ(CU_BRANZ),
        .CU_BRAUNCOND(CU_BRAUNCOND), .ZERO(ZERO), .REG_WE(REG_WE), .PC(PC),
        .BUSY(BUSY), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .RETIRED(RETIRED)
    );

    // Free-running clock, period 10
    always #5 CLK = ~CLK;

    // Bench instruction set: returns {writeenable, braz, branz, brauncond}
    function automatic logic [3:0] cu_of(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2:         cu_of = 4'b1000;
            4'h4:                     cu_of = 4'b0100;
            4'h5:                     cu_of = 4'b0010;
            4'h6:                     cu_of = 4'b0001;
            4'hC, 4'hD, 4'hE, 4'hF:   cu_of = 4'b1000;
            default:                  cu_of = 4'b0000;
        endcase
    endfunction

    assign {CU_WRITEENABLE, CU_BRAZ, CU_BRANZ, CU_BRAUNCOND} = cu_of(OPCODE);

    function automatic logic [31:0] mk_instr(input logic [3:0] op, input logic [7:0] off);
        mk_instr = {4'h0, op, 16'hA5A5, off};
    endfunction

    function automatic exp_t mk_rec(input logic req, input logic busy, input logic halted,
                                    input logic we, input logic irv, input logic [31:0] ir);
        exp_t r;
        r.req      = req;
        r.busy     = busy;
        r.halted   = halted;
        r.reg_we   = we;
        r.pc       = m_pc;
        r.ret      = m_ret;
        r.ill      = m_ill;
        r.ir_valid = irv;
        r.ir       = ir;
        return r;
    endfunction

    task automatic retire_model();
        if (m_ret != RET_MAX) m_ret = m_ret + 4'd1;
    endtask

    // Expand n instructions from the model PC into per-cycle expectations
    task automatic build_expect(input int n, input int d, input logic z, output int drop_at);
        logic [31:0] ins;
        logic [3:0]  op;
        logic [3:0]  cu;
        logic [7:0]  off;
        logic        tk;
        drop_at = 0;
        for (int i = 0; i < n; i++) begin
            if (m_halt) break;
            ins = mem[m_pc];
            op  = ins[27:24];
            off = ins[7:0];
            cu  = cu_of(op);
            if (i == n - 1) drop_at = exp_q.size() + 1;
            for (int f = 0; f <= d; f++) exp_q.push_back(mk_rec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0));
            exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ins));
            if (op >= 4'hC) begin
                m_ill = 1'b1;
`ifdef SEQ_HALT_ON_ILLEGAL_EN
                m_halt = 1'b1;
`else
                exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ins));
                m_pc = m_pc + 8'd1;
                retire_model();
`endif
            end else if (cu[2:0] != 3'b000) begin
                exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ins));
                tk   = cu[0] | (cu[2] & z) | (cu[1] & ~z);
                m_pc = tk ? (m_pc + 8'd1 + off) : (m_pc + 8'd1);
                retire_model();
            end else begin
                exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ins));
                exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, cu[3], 1'b1, ins));
                m_pc = m_pc + 8'd1;
                retire_model();
            end
        end
        repeat (2) exp_q.push_back(m_halt ? mk_rec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0)
                                          : mk_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Run a program segment: RUN high, dropped during the last instruction's first fetch cycle
    task automatic applyStimulus(input int n, input int d, input logic z, input logic extra);
        int drop;
        int len;
        ack_delay = d;
        extra_ack = extra;
        ZERO      = z;
        we_log.delete();
        req_log.delete();
        @(negedge CLK);
        run_cycle = 0;
        build_expect(n, d, z, drop);
        len = exp_q.size();
        RUN = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge CLK);
            if (k == drop) RUN = 1'b0;
        end
        RUN = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        RUN     = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_pc", 32'(PC), 32'h0);
        checkOutput("rst_addr", 32'(IMEM_ADDR), 32'h0);
        checkOutput("rst_req", 32'(IMEM_REQ), 32'h0);
        checkOutput("rst_reg_we", 32'(REG_WE), 32'h0);
        checkOutput("rst_busy", 32'(BUSY), 32'h0);
        checkOutput("rst_halted", 32'(HALTED), 32'h0);
        checkOutput("rst_illegal", 32'(ILLEGAL), 32'h0);
        checkOutput("rst_retired", 32'(RETIRED), 32'h0);
        checkOutput("rst_ir", INSTRUCTION, 32'h0);
        checkOutput("rst_opcode", 32'(OPCODE), 32'h0);
        RESET_N = 1'b1;
        m_pc    = 8'h0;
        m_ret   = 4'h0;
        m_ill   = 1'b0;
        m_halt  = 1'b0;
    endtask

    // Instruction memory responder: ack after ack_delay waiting cycles, optional stray ack after
    always @(posedge CLK) begin
        #1;
        if (ack_hold) begin
            IMEM_ACK  = 1'b1;
            IMEM_DATA = 32'hFFFF_FFFF;
            ack_hold  = 1'b0;
        end else if (IMEM_REQ) begin
            if (wait_cnt >= ack_delay) begin
                IMEM_ACK  = 1'b1;
                IMEM_DATA = mem[IMEM_ADDR];
                wait_cnt  = 0;
                ack_hold  = extra_ack;
            end else begin
                IMEM_ACK  = 1'b0;
                IMEM_DATA = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            IMEM_ACK = 1'b0;
            wait_cnt = 0;
        end
    end

    // Per-cycle compare of DUT outputs against the queued model expectations
    always @(posedge CLK) begin
        #2;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            run_cycle++;
            checkOutput("req", 32'(IMEM_REQ), 32'(cur.req));
            checkOutput("busy", 32'(BUSY), 32'(cur.busy));
            checkOutput("halted", 32'(HALTED), 32'(cur.halted));
            checkOutput("reg_we", 32'(REG_WE), 32'(cur.reg_we));
            checkOutput("pc", 32'(PC), 32'(cur.pc));
            checkOutput("imem_addr", 32'(IMEM_ADDR), 32'(cur.pc));
            checkOutput("retired", 32'(RETIRED), 32'(cur.ret));
            checkOutput("illegal", 32'(ILLEGAL), 32'(cur.ill));
            if (cur.ir_valid) begin
                checkOutput("instruction", INSTRUCTION, cur.ir);
                checkOutput("opcode", 32'(OPCODE), 32'(cur.ir[27:24]));
            end
            if (REG_WE) we_log.push_back(run_cycle);
            if (IMEM_REQ) req_log.push_back(int'(IMEM_ADDR));
        end
    end

    // Watchdog so the run always ends with a summary
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Directed test sequence
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = mk_instr(4'h7, 8'h00);
        mem[0] = mk_instr(4'h0, 8'h00);
        mem[1] = mk_instr(4'h1, 8'h00);

        do_reset();

        // Reset during FETCH with a simultaneous ack: the fetch is abandoned
        @(negedge CLK);
        RUN = 1'b1;
        @(negedge CLK);
        checkOutput("fetch_req_before_rst", 32'(IMEM_REQ), 32'h1);
        RESET_N = 1'b0;
        RUN     = 1'b0;
        @(negedge CLK);
        checkOutput("rst_ack_ir", INSTRUCTION, 32'h0);
        checkOutput("rst_ack_req", 32'(IMEM_REQ), 32'h0);
        checkOutput("rst_ack_busy", 32'(BUSY), 32'h0);
        RESET_N = 1'b1;

        // add, addi back to back with immediate ack
        applyStimulus(2, 0, 1'b0, 1'b0);
        checkOutput("we_count", 32'(we_log.size()), 32'd2);
        checkOutput("we_cycle_a", (we_log.size() > 0) ? 32'(we_log[0]) : 32'h0, 32'd4);
        checkOutput("we_cycle_b", (we_log.size() > 1) ? 32'(we_log[1]) : 32'h0, 32'd8);
        checkOutput("addpair_pc", 32'(PC), 32'd2);
        checkOutput("addpair_retired", 32'(RETIRED), 32'd2);
        checkOutput("addpair_idle_busy", 32'(BUSY), 32'd0);

        // braz at PC 5, offset -3, taken and then not taken
        mem[2] = mk_instr(4'h2, 8'h00);
        mem[3] = mk_instr(4'h3, 8'h00);
        mem[4] = mk_instr(4'h7, 8'h00);
        mem[5] = mk_instr(4'h4, 8'hFD);
        applyStimulus(4, 0, 1'b1, 1'b0);
        checkOutput("braz_taken_pc", 32'(PC), 32'd3);
        checkOutput("braz_taken_retired", 32'(RETIRED), 32'd6);
        applyStimulus(3, 0, 1'b0, 1'b0);
        checkOutput("braz_fall_pc", 32'(PC), 32'd6);
        checkOutput("braz_fall_retired", 32'(RETIRED), 32'd9);

        // Ack delayed three cycles plus a stray ack in DECODE
        mem[6] = mk_instr(4'h0, 8'h00);
        applyStimulus(1, 3, 1'b0, 1'b1);
        checkOutput("delay_req_cycles", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < req_log.size(); i++) checkOutput("delay_req_addr", 32'(req_log[i]), 32'd6);
        checkOutput("delay_pc", 32'(PC), 32'd7);

        // brauncond to 0xFE, then brauncond +3 wraps to 0x02
        mem[7]     = mk_instr(4'h6, 8'hF6);
        mem[8'hFE] = mk_instr(4'h6, 8'h03);
        applyStimulus(2, 1, 1'b0, 1'b0);
        checkOutput("wrap_pc", 32'(PC), 32'd2);
        checkOutput("wrap_retired", 32'(RETIRED), 32'd12);

        // branz taken, braz not taken, add; retired count saturates
        mem[3] = mk_instr(4'h5, 8'h01);
        applyStimulus(4, 0, 1'b0, 1'b0);
        checkOutput("branz_pc", 32'(PC), 32'd7);
        checkOutput("retired_sat", 32'(RETIRED), 32'd15);

        // Illegal opcode 4'hE, then one more instruction
        mem[7] = mk_instr(4'hE, 8'h00);
        mem[8] = mk_instr(4'h0, 8'h00);
        applyStimulus(1, 0, 1'b0, 1'b0);
        checkOutput("illegal_flag", 32'(ILLEGAL), 32'd1);
`ifdef SEQ_HALT_ON_ILLEGAL_EN
        checkOutput("illegal_halted", 32'(HALTED), 32'd1);
        checkOutput("illegal_pc", 32'(PC), 32'd7);
`else
        checkOutput("illegal_halted", 32'(HALTED), 32'd0);
        checkOutput("illegal_pc", 32'(PC), 32'd8);
`endif
        applyStimulus(1, 0, 1'b0, 1'b0);
        checkOutput("illegal_sticky", 32'(ILLEGAL), 32'd1);

        // Reset during WB of an add: no write strobe after the reset edge
        do_reset();
        ack_delay = 0;
        extra_ack = 1'b0;
        @(negedge CLK);
        RUN = 1'b1;
        repeat (4) @(negedge CLK);
        checkOutput("wb_reg_we", 32'(REG_WE), 32'd1);
        RESET_N = 1'b0;
        RUN     = 1'b0;
        @(negedge CLK);
        checkOutput("wbrst_reg_we", 32'(REG_WE), 32'd0);
        checkOutput("wbrst_pc", 32'(PC), 32'd0);
        checkOutput("wbrst_retired", 32'(RETIRED), 32'd0);
        checkOutput("wbrst_busy", 32'(BUSY), 32'd0);
        checkOutput("wbrst_ir", INSTRUCTION, 32'h0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
